// File: rtl/current_off_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | current_off_pkg : shared types and width helpers for current-off path    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package current_off_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ARMED    = 3'd0,
    DEBOUNCE = 3'd1,
    TRIPPED  = 3'd2,
    COOLDOWN = 3'd3,
    LOCKOUT  = 3'd4
  } fault_state_t;

  // Width of a counter that must hold values 0..max_val without wrapping.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdc_sync_bit : multi-flop synchroniser for one asynchronous input bit    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/current_fault_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | current_fault_ctrl : overcurrent debounce, trip, cooldown and lockout    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module current_fault_ctrl
  import current_off_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 1000,
  parameter int MAX_TRIPS       = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         oc_in,
  input  logic                         fault_clr,
  output logic                         dis_output,
  output logic                         lockout,
  output logic [cnt_w(MAX_TRIPS)-1:0]  trip_cnt,
  output logic [STATE_W-1:0]           fault_state
);

  localparam int DEB_W  = cnt_w(DEBOUNCE_CYCLES);
  localparam int CD_W   = cnt_w(COOLDOWN_CYCLES);
  localparam int TRIP_W = cnt_w(MAX_TRIPS);

  // Counters compare against "last" so the increment itself never needs to hold N.
  localparam logic [DEB_W-1:0]  c_deb_last = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0]   c_cd_last  = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TRIP_W-1:0] c_trip_max = TRIP_W'(MAX_TRIPS);

  logic w_oc_sync;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_oc_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (oc_in),
    .q       (w_oc_sync)
  );

  fault_state_t      r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [CD_W-1:0]   r_cd_cnt;
  logic [TRIP_W-1:0] r_trip_cnt;
  logic              r_dis;
  logic              r_lockout;

  fault_state_t      w_state_nxt;
  logic [DEB_W-1:0]  w_deb_nxt;
  logic [CD_W-1:0]   w_cd_nxt;
  logic [TRIP_W-1:0] w_trip_nxt;
  logic              w_trip;

  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_cd_nxt    = r_cd_cnt;
    w_trip_nxt  = r_trip_cnt;
    w_trip      = 1'b0;
    case (r_state)
      ARMED: begin
        if (fault_clr) w_trip_nxt = '0;
        if (w_oc_sync) begin
          if (c_deb_last == '0) begin
            w_trip = 1'b1;
          end else begin
            w_state_nxt = DEBOUNCE;
            w_deb_nxt   = DEB_W'(1);
          end
        end
      end
      DEBOUNCE: begin
        if (!w_oc_sync) begin
          w_state_nxt = ARMED;
          w_deb_nxt   = '0;
        end else if (r_deb_cnt == c_deb_last) begin
          w_trip    = 1'b1;
          w_deb_nxt = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      TRIPPED: begin
        if (!w_oc_sync) begin
          w_state_nxt = COOLDOWN;
          w_cd_nxt    = '0;
        end
      end
      COOLDOWN: begin
        // A returning fault restarts the quiet period rather than re-tripping.
        if (w_oc_sync) begin
          w_cd_nxt = '0;
        end else if (r_cd_cnt == c_cd_last) begin
          w_state_nxt = ARMED;
          w_cd_nxt    = '0;
        end else begin
          w_cd_nxt = r_cd_cnt + CD_W'(1);
        end
      end
      LOCKOUT: begin
        if (fault_clr && !w_oc_sync) begin
          w_state_nxt = ARMED;
          w_trip_nxt  = '0;
        end
      end
      default: w_state_nxt = ARMED;
    endcase

    if (w_trip) begin
      if (w_trip_nxt != c_trip_max) w_trip_nxt = w_trip_nxt + TRIP_W'(1);
      w_state_nxt = (w_trip_nxt == c_trip_max) ? LOCKOUT : TRIPPED;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARMED;
      r_deb_cnt  <= '0;
      r_cd_cnt   <= '0;
      r_trip_cnt <= '0;
      r_dis      <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_deb_cnt  <= w_deb_nxt;
      r_cd_cnt   <= w_cd_nxt;
      r_trip_cnt <= w_trip_nxt;
      r_dis      <= (w_state_nxt == TRIPPED) || (w_state_nxt == COOLDOWN) ||
                    (w_state_nxt == LOCKOUT);
      r_lockout  <= (w_state_nxt == LOCKOUT);
    end
  end

  assign dis_output  = r_dis;
  assign lockout     = r_lockout;
  assign trip_cnt    = r_trip_cnt;
  assign fault_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_current_fault_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_current_fault_ctrl : directed and random checks against a run-length  |
// | behavioural model. Rev 1.0                                               |
// +--------------------------------------------------------------------------+
module tb_current_fault_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int CD   = 10;
  localparam int MAXT = 2;
  localparam int TW   = $clog2(MAXT + 1);

  localparam int S_ARMED = 0, S_DEB = 1, S_TRIP = 2, S_COOL = 3, S_LOCK = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          oc_in = 1'b0;
  logic          fault_clr = 1'b0;
  logic          dis_output;
  logic          lockout;
  logic [TW-1:0] trip_cnt;
  logic [2:0]    fault_state;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: oc_in delayed through a queue, then run lengths of high/low samples.
  int sq[$];
  bit m_dis, m_locked, m_restart;
  int m_trips, m_hi_run, m_lo_run;

  current_fault_ctrl #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .COOLDOWN_CYCLES (CD),
    .MAX_TRIPS       (MAXT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .oc_in       (oc_in),
    .fault_clr   (fault_clr),
    .dis_output  (dis_output),
    .lockout     (lockout),
    .trip_cnt    (trip_cnt),
    .fault_state (fault_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < SYNC; i++) sq.push_back(0);
    m_dis = 0; m_locked = 0; m_restart = 0;
    m_trips = 0; m_hi_run = 0; m_lo_run = 0;
  endtask

  function automatic int model_state();
    if (m_locked) return S_LOCK;
    if (m_dis) return (m_lo_run == 0 && !m_restart) ? S_TRIP : S_COOL;
    return (m_hi_run > 0) ? S_DEB : S_ARMED;
  endfunction

  task automatic model_edge(input bit oc, input bit clr);
    int sync;
    sync = sq.pop_front();
    sq.push_back(int'(oc));
    if (m_locked) begin
      if (clr && sync == 0) begin
        m_locked = 0; m_dis = 0; m_trips = 0;
      end
    end else if (m_dis) begin
      if (sync != 0) begin
        if (m_lo_run > 0) m_restart = 1;
        m_lo_run = 0;
      end else begin
        m_lo_run++;
        // From a fresh trip the first quiet sample only enters cooldown.
        if (m_lo_run == (m_restart ? CD : CD + 1)) m_dis = 0;
      end
    end else begin
      if (clr && m_hi_run == 0) m_trips = 0;
      m_hi_run = (sync != 0) ? m_hi_run + 1 : 0;
      if (m_hi_run == DEB) begin
        m_hi_run  = 0;
        m_trips   = (m_trips + 1 > MAXT) ? MAXT : m_trips + 1;
        m_dis     = 1;
        m_locked  = (m_trips == MAXT);
        m_lo_run  = 0;
        m_restart = 0;
      end
    end
  endtask

  task automatic check_all();
    check_val("dis_output", dis_output, m_dis);
    check_val("lockout", lockout, m_locked);
    check_val("trip_cnt", trip_cnt, m_trips);
    check_val("fault_state", fault_state, model_state());
  endtask

  task automatic step(input bit oc, input bit clr);
    oc_in = oc;
    fault_clr = clr;
    @(posedge clk);
    model_edge(oc, clr);
    #1;
    check_all();
  endtask

  initial begin
    int lat;
    bit prev_clr;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check_val("reset_dis", dis_output, 0);
    check_val("reset_state", fault_state, S_ARMED);
    #3 reset_n = 1'b1;

    // Glitch shorter than the debounce window.
    repeat (3) step(1, 0);
    repeat (6) step(0, 0);
    check_val("glitch_dis", dis_output, 0);
    check_val("glitch_trips", trip_cnt, 0);
    check_val("glitch_state", fault_state, S_ARMED);

    // Sustained fault: trip latency measured from edge 0.
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 0);
      if (dis_output === 1'b1 && lat < 0) lat = i;
    end
    check_val("trip_latency", lat, SYNC + DEB - 1);
    check_val("trip_count1", trip_cnt, 1);
    check_val("trip_state", fault_state, S_TRIP);

    // Release latency.
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0);
      if (dis_output === 1'b0 && lat < 0) lat = i;
    end
    check_val("release_latency", lat, SYNC + CD);
    check_val("release_state", fault_state, S_ARMED);

    step(0, 1);
    check_val("armed_clr", trip_cnt, 0);

    // Cooldown restart by a one-cycle fault.
    repeat (8) step(1, 0);
    repeat (8) step(0, 0);
    check_val("cool_state", fault_state, S_COOL);
    step(1, 0);
    lat = -1;
    for (int j = 1; j < 24; j++) begin
      step(0, 0);
      if (dis_output === 1'b0 && lat < 0) lat = j;
    end
    check_val("restart_latency", lat, SYNC + CD);
    check_val("restart_trips", trip_cnt, 1);

    // Second trip reaches MAX_TRIPS: lockout.
    repeat (8) step(1, 0);
    check_val("lock_flag", lockout, 1);
    check_val("lock_trips", trip_cnt, MAXT);
    check_val("lock_state", fault_state, S_LOCK);
    step(1, 1);
    check_val("clr_ignored_hi", lockout, 1);
    repeat (500) step(0, 0);
    check_val("lock_hold_dis", dis_output, 1);
    step(0, 1);
    check_val("unlock_dis", dis_output, 0);
    check_val("unlock_flag", lockout, 0);
    check_val("unlock_trips", trip_cnt, 0);

    // Asynchronous reset in mid-cooldown, between edges.
    repeat (8) step(1, 0);
    repeat (6) step(0, 0);
    check_val("pre_reset_state", fault_state, S_COOL);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_val("async_dis", dis_output, 0);
    check_val("async_trips", trip_cnt, 0);
    check_val("async_state", fault_state, S_ARMED);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomised runs of high/low with sparse clear pulses.
    prev_clr = 0;
    for (int r = 0; r < 300; r++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = lvl ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 16));
      for (int k = 0; k < len; k++) begin
        bit c;
        c = !prev_clr && ($urandom_range(0, 7) == 0);
        step(lvl, c);
        prev_clr = c;
      end
    end
    step(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
